// File: rtl/rib_pkg.sv
// Shared types and constants for the RIB data-bus arbiter (rib_arb and rib_arb_pick).
package rib_pkg;

  localparam int RIB_ADDR_W = 32;
  localparam int RIB_DATA_W = 32;

  // Read data returned to a master whose transaction timed out.
  localparam logic [RIB_DATA_W-1:0] RIB_TIMEOUT_RDATA = 32'h0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } rib_arb_state_e;

  typedef enum logic [2:0] {
    BYTE = 3'd0,
    HALF = 3'd1,
    WORD = 3'd2
  } size_e;

endpackage

// File: rtl/rib_arb_pick.sv
// Combinational winner search: first requester found scanning upward from start_i, wrapping at N.
// A start of 0 gives plain lowest-index-wins priority.
module rib_arb_pick #(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          found_o
);

  logic [IW-1:0] cand;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    found_o = 1'b0;
    cand    = '0;
    for (int off = 0; off < N; off++) begin
      cand = IW'((int'(start_i) + off) % N);
      if (!found_o && req_i[cand]) begin
        found_o     = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/rib_arb.sv
// Single-port data-bus arbiter: one transaction at a time, IDLE -> BUSY -> RESP -> IDLE.
// Define RIB_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (m0 highest).
module rib_arb
  import rib_pkg::*;
#(
  parameter int NUM_MASTERS    = 3,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_MASTERS-1:0]            m_req_i,
  input  logic [NUM_MASTERS*RIB_ADDR_W-1:0] m_addr_i,
  input  logic [NUM_MASTERS*RIB_DATA_W-1:0] m_wdata_i,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  input  logic [NUM_MASTERS*3-1:0]          m_size_i,
  output logic [NUM_MASTERS-1:0]            m_gnt_o,
  output logic [NUM_MASTERS-1:0]            m_ack_o,
  output logic [NUM_MASTERS-1:0]            m_err_o,
  output logic [RIB_DATA_W-1:0]             m_rdata_o,
  output logic [NUM_MASTERS-1:0]            hold_o,
  output logic                              s_req_o,
  output logic [RIB_ADDR_W-1:0]             s_addr_o,
  output logic [RIB_DATA_W-1:0]             s_wdata_o,
  output logic                              s_we_o,
  output logic [2:0]                        s_size_o,
  input  logic [RIB_DATA_W-1:0]             s_rdata_i,
  input  logic                              s_ack_i,
  output rib_arb_state_e                    dbg_state_o
);

  localparam int N     = NUM_MASTERS;
  localparam int IW    = $clog2(N);
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  rib_arb_state_e        state_q, state_d;
  logic [N-1:0]          gnt_q, gnt_d;
  logic [N-1:0]          ack_q, ack_d;
  logic [N-1:0]          err_q, err_d;
  logic [RIB_DATA_W-1:0] rdata_q, rdata_d;
  logic                  s_req_q, s_req_d;
  logic [RIB_ADDR_W-1:0] addr_q, addr_d;
  logic [RIB_DATA_W-1:0] wdata_q, wdata_d;
  logic                  we_q, we_d;
  size_e                 size_q, size_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [IW-1:0] pick_start;
  logic [N-1:0]  pick_gnt;
  logic [IW-1:0] pick_idx;
  logic          pick_found;

`ifdef RIB_ARB_RR_EN
  logic [IW-1:0] ptr_q, ptr_d;
  assign pick_start = ptr_q;
`else
  assign pick_start = '0;
`endif

  rib_arb_pick #(.N(N), .IW(IW)) u_pick (
    .req_i   (m_req_i),
    .start_i (pick_start),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    err_d   = '0;
    rdata_d = '0;
    s_req_d = s_req_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    size_d  = size_q;
    cnt_d   = cnt_q;
`ifdef RIB_ARB_RR_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = BUSY;
          gnt_d   = pick_gnt;
          s_req_d = 1'b1;
          addr_d  = m_addr_i[pick_idx*RIB_ADDR_W +: RIB_ADDR_W];
          wdata_d = m_wdata_i[pick_idx*RIB_DATA_W +: RIB_DATA_W];
          we_d    = m_we_i[pick_idx];
          size_d  = size_e'(m_size_i[pick_idx*3 +: 3]);
          cnt_d   = '0;
`ifdef RIB_ARB_RR_EN
          ptr_d   = IW'((int'(pick_idx) + 1) % N);
`endif
        end
      end
      BUSY: begin
        if (s_ack_i) begin
          state_d = RESP;
          s_req_d = 1'b0;
          ack_d   = gnt_q;
          rdata_d = s_rdata_i;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
          state_d = RESP;
          s_req_d = 1'b0;
          ack_d   = gnt_q;
          err_d   = gnt_q;
          rdata_d = RIB_TIMEOUT_RDATA;
        end else if (TIMEOUT_CYCLES != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        // Always pass through IDLE so the owner can drop its request first.
        state_d = IDLE;
        gnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        s_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ack_q   <= '0;
      err_q   <= '0;
      rdata_q <= '0;
      s_req_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      size_q  <= BYTE;
      cnt_q   <= '0;
`ifdef RIB_ARB_RR_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      s_req_q <= s_req_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      size_q  <= size_d;
      cnt_q   <= cnt_d;
`ifdef RIB_ARB_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign m_gnt_o     = gnt_q;
  assign m_ack_o     = ack_q;
  assign m_err_o     = err_q;
  assign m_rdata_o   = rdata_q;
  assign hold_o      = m_req_i & ~ack_q;
  assign s_req_o     = s_req_q;
  assign s_addr_o    = addr_q;
  assign s_wdata_o   = wdata_q;
  assign s_we_o      = we_q;
  assign s_size_o    = size_q;
  assign dbg_state_o = state_q;

endmodule
